// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - word-serial sequencer around an external Adder; optional subtract via SERIAL_ADD_SUB_EN
module serial_add_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  a_in,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  b_in,
    input  logic                             cin_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                             sub,
`endif
    output logic [DATA_WIDTH-1:0]            add_in0,
    output logic [DATA_WIDTH-1:0]            add_in1,
    output logic                             add_cin,
    input  logic [DATA_WIDTH-1:0]            add_sum,
    input  logic                             add_cout,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_WIDTH*NUM_WORDS-1:0]  result,
    output logic                             cout,
    output logic                             overflow
);
    localparam int TW    = DATA_WIDTH * NUM_WORDS;
    localparam int IDX_W = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [TW-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
    logic              cout_q, cout_d, ovf_q, ovf_d;
    logic              sub_q, sub_d;
    logic [DATA_WIDTH-1:0] a_word, b_word, b_eff;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_sel;
    assign sub_sel = sub;
`else
    logic sub_sel;
    assign sub_sel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sub_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            sub_q    <= sub_d;
        end
    end

    // Word select muxes over the latched operands
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                a_word = a_q[w*DATA_WIDTH +: DATA_WIDTH];
                b_word = b_q[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        b_eff = sub_q ? ~b_word : b_word;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        sub_d    = sub_q;
        add_in0  = '0;
        add_in1  = '0;
        add_cin  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a_in;
                    b_d      = b_in;
                    sub_d    = sub_sel;
                    carry_d  = sub_sel ? 1'b1 : cin_in;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                add_in0 = a_word;
                add_in1 = b_eff;
                add_cin = carry_q;
                for (int w = 0; w < NUM_WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        result_d[w*DATA_WIDTH +: DATA_WIDTH] = add_sum;
                    end
                end
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                    cout_d  = add_cout;
                    ovf_d   = (a_word[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                              (add_sum[DATA_WIDTH-1] != a_word[DATA_WIDTH-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed bench for serial_add_ctrl with a behavioural Adder
module tb_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        cin_in;
    logic        sub;
    logic [7:0]  add_in0, add_in1, add_sum;
    logic        add_cin, add_cout;
    logic        busy, done, cout, overflow;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_in0} + {1'b0, add_in1} + {8'b0, add_cin};

    serial_add_ctrl #(.DATA_WIDTH(8), .NUM_WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .add_in0(add_in0), .add_in1(add_in1), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
    );

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
        int guard = 0;
        @(negedge clk);
        while (busy === 1'b1 && guard < 20) begin
            cycle();
            guard++;
        end
        a_in = a; b_in = b; cin_in = c; start = 1'b1;
        cycle();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        if (lat >= 20) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a_in = 32'hDEADBEEF; b_in = 32'h1; cin_in = 1'b1; sub = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({busy, done, cout, overflow} !== 4'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_out busy=%b done=%b cout=%b ovf=%b result=%h required all 0",
                     busy, done, cout, overflow, result);
        end
        checks++;
        if (add_in0 !== 8'h0 || add_in1 !== 8'h0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_add in0=%h in1=%h cin=%b required 0", add_in0, add_in1, add_cin);
        end
        start = 1'b0;
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_carry_chain();
        int lat;
        do_op(32'h000000FF, 32'h00000001, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL chain_latency got %0d required 4", lat);
        end
        checks++;
        if (result !== 32'h00000100 || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL chain_result result=%h cout=%b ovf=%b required 00000100 0 0", result, cout, overflow);
        end
        cycle();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b required 0 0", done, busy);
        end
        checks++;
        if (result !== 32'h00000100) begin
            errors++;
            $display("FAIL result_hold result=%h required 00000100", result);
        end
    endtask

    task automatic test_wrap();
        int lat;
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
        checks++;
        if (lat !== 4 || result !== 32'h0 || cout !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_plus1 lat=%0d result=%h cout=%b ovf=%b required 4 00000000 1 0",
                     lat, result, cout, overflow);
        end
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
        checks++;
        if (lat !== 4 || result !== 32'h0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL wrap_cin lat=%0d result=%h cout=%b required 4 00000000 1", lat, result, cout);
        end
    endtask

    task automatic test_overflow();
        int lat;
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        checks++;
        if (lat !== 4 || result !== 32'h80000000 || overflow !== 1'b1 || cout !== 1'b0) begin
            errors++;
            $display("FAIL signed_ovf lat=%0d result=%h ovf=%b cout=%b required 4 80000000 1 0",
                     lat, result, overflow, cout);
        end
    endtask

    task automatic test_mid_start();
        int lat = 0;
        @(negedge clk);
        a_in = 32'h01020304; b_in = 32'h10203040; cin_in = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        a_in = 32'hFFFF0000; b_in = 32'h0000FFFF; cin_in = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        while (done !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        checks++;
        if (done !== 1'b1 || result !== 32'h11223344 || cout !== 1'b0) begin
            errors++;
            $display("FAIL mid_start done=%b result=%h cout=%b required 1 11223344 0", done, result, cout);
        end
        cycle();
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_queue busy=%b required 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        bit saw_done = 0;
        @(negedge clk);
        a_in = 32'h000000FF; b_in = 32'h000000FF; cin_in = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({busy, done, cout, overflow} !== 4'b0 || result !== 32'h0 || add_in0 !== 8'h0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy=%b done=%b cout=%b ovf=%b result=%h in0=%h cin=%b required all 0",
                     busy, done, cout, overflow, result, add_in0, add_cin);
        end
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) saw_done = 1;
            cycle();
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done saw done=1 required 0");
        end
        do_op(32'h12345678, 32'h11111111, 1'b0, lat);
        checks++;
        if (lat !== 4 || result !== 32'h23456789 || cout !== 1'b0) begin
            errors++;
            $display("FAIL after_reset lat=%0d result=%h cout=%b required 4 23456789 0", lat, result, cout);
        end
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        int lat = 0;
        @(negedge clk);
        while (busy === 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        a_in = 32'h00010000; b_in = 32'h0000FFFF; cin_in = 1'b0; start = 1'b1;
        cycle();
        a_in = 32'hA5A5A5A5; b_in = 32'h5A5A5A5A;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        checks++;
        if (done !== 1'b1 || result !== 32'h0001FFFF) begin
            errors++;
            $display("FAIL b2b_first done=%b result=%h required 1 0001FFFF", done, result);
        end
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap busy=%b required 0", busy);
        end
        gap = 1;
        while (done !== 1'b1 && gap < 20) begin
            cycle();
            gap++;
        end
        start = 1'b0;
        checks++;
        if (gap !== 6 || result !== 32'hFFFFFFFF || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second gap=%0d result=%h cout=%b required 6 FFFFFFFF 0", gap, result, cout);
        end
        cycle();
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int lat;
        sub = 1'b1;
        do_op(32'h00000000, 32'h00000001, 1'b0, lat);
        checks++;
        if (lat !== 4 || result !== 32'hFFFFFFFF || cout !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow lat=%0d result=%h cout=%b required 4 FFFFFFFF 0", lat, result, cout);
        end
        do_op(32'h80000000, 32'h00000001, 1'b0, lat);
        checks++;
        if (lat !== 4 || result !== 32'h7FFFFFFF || overflow !== 1'b1 || cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf lat=%0d result=%h ovf=%b cout=%b required 4 7FFFFFFF 1 1",
                     lat, result, overflow, cout);
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_carry_chain();
        test_wrap();
        test_overflow();
        test_mid_start();
        test_mid_reset();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
